// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate L1 data cache
// controller between the CPU MEM stage and off-chip data memory.
// 4-word (128-bit) lines; 2^INDEX_BITS lines; hits complete with no added latency.
// Optional build macro DCACHE_STATS_EN adds hit/miss counters.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   cpu_req_i, cpu_we_i      MEM-stage access valid, 1 = store
//   cpu_addr_i, cpu_data_i   byte address, store data
//   cpu_data_o               load data (0 unless a load hits in IDLE)
//   cpu_stall_o              freeze PC and pipeline registers
//   mem_req_o, mem_we_o      memory request, 1 = line write-back
//   mem_addr_o, mem_data_o   line-aligned address, write-back line
//   mem_data_i, mem_ack_i    refill line, one-cycle completion pulse
//   hit_cnt_o, miss_cnt_o    (DCACHE_STATS_EN only) access statistics
module dcache_ctrl #(
  parameter int unsigned INDEX_BITS = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_we_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [127:0] mem_data_o,
  input  logic [127:0] mem_data_i,
`ifdef DCACHE_STATS_EN
  input  logic         mem_ack_i,
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o
`else
  input  logic         mem_ack_i
`endif
);

  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = 28 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t state, state_nxt;

  logic [LINES-1:0] valid, dirty;
  logic [TAG_W-1:0] tags  [LINES];
  logic [127:0]     lines [LINES];

  logic [1:0]            word;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      req_tag;
  logic                  hit, wr_hit, fill, miss_start;
  logic                  unused_byte_sel;

  assign word            = cpu_addr_i[3:2];
  assign idx             = cpu_addr_i[3+INDEX_BITS:4];
  assign req_tag         = cpu_addr_i[31:4+INDEX_BITS];
  assign unused_byte_sel = ^cpu_addr_i[1:0];
  assign hit             = cpu_req_i & valid[idx] & (tags[idx] == req_tag);

  always_comb begin
    state_nxt   = state;
    cpu_data_o  = '0;
    cpu_stall_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    wr_hit      = 1'b0;
    fill        = 1'b0;
    miss_start  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req_i) begin
          if (hit) begin
            wr_hit = cpu_we_i;
            if (!cpu_we_i) cpu_data_o = lines[idx][{word, 5'b0} +: 32];
          end else begin
            cpu_stall_o = 1'b1;
            miss_start  = 1'b1;
            state_nxt   = (valid[idx] & dirty[idx]) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {tags[idx], idx, 4'b0};
        mem_data_o  = lines[idx];
        if (mem_ack_i) state_nxt = ALLOCATE;
      end
      ALLOCATE: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_addr_o  = {req_tag, idx, 4'b0};
        if (mem_ack_i) begin
          fill      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= state_nxt;
      if (fill) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end
      if (wr_hit) dirty[idx] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset: a cleared valid bit masks stale contents.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (fill) begin
        tags[idx]  <= req_tag;
        lines[idx] <= mem_data_i;
      end else if (wr_hit) begin
        lines[idx][{word, 5'b0} +: 32] <= cpu_data_i;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  // The access after a refill replays as a hit; it was already counted as a miss.
  logic replay;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      replay     <= 1'b0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      replay <= fill;
      if (miss_start) miss_cnt_o <= miss_cnt_o + 32'd1;
      if ((state == IDLE) && hit && !replay) hit_cnt_o <= hit_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed self-checking bench for dcache_ctrl.
// A memory responder acks each request ACK_DLY cycles after it first sees it
// and logs every completed transaction for later checking.
module tb_dcache_ctrl;

  localparam int ACK_DLY = 3;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         cpu_req_i = 1'b0, cpu_we_i = 1'b0;
  logic [31:0]  cpu_addr_i = '0, cpu_data_i = '0;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o, mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_data_o;
  logic [127:0] mem_data_i = '0;
  logic         resp_ack = 1'b0, stray_ack = 1'b0, ack_hold = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif

  assign mem_ack_i = resp_ack | stray_ack;

  always #5 clk = ~clk;

  dcache_ctrl #(.INDEX_BITS(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i),
`ifdef DCACHE_STATS_EN
    .mem_ack_i(mem_ack_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`else
    .mem_ack_i(mem_ack_i)
`endif
  );

  assert property (@(posedge clk) disable iff (rst_i)
    cpu_stall_o |=> $stable({cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i}));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model, indexed by address bits [11:4]; word k of line i = i*16 + 4k.
  logic [127:0] mem_model [256];
  int           ack_cnt = 0;
  int           n_txn = 0;
  logic         txn_we   [16];
  logic [31:0]  txn_addr [16];
  logic [127:0] txn_data [16];

  always @(negedge clk) begin
    resp_ack = 1'b0;
    if (!mem_req_o) begin
      ack_cnt = 0;
    end else if (!ack_hold) begin
      if (ack_cnt == ACK_DLY) begin
        resp_ack = 1'b1;
        ack_cnt  = 0;
        if (n_txn < 16) begin
          txn_we[n_txn]   = mem_we_o;
          txn_addr[n_txn] = mem_addr_o;
          txn_data[n_txn] = mem_data_o;
        end
        n_txn++;
        if (mem_we_o) mem_model[mem_addr_o[11:4]] = mem_data_o;
        else          mem_data_i = mem_model[mem_addr_o[11:4]];
      end else begin
        ack_cnt++;
      end
    end
  end

  // One CPU access starting on a falling edge: counts stalled cycles, captures
  // the data seen on the completing cycle, then lets that edge retire it.
  task automatic acc(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input int exp_stalls,
                     input logic [31:0] exp_rdata, input int exp_txns);
    int stalls;
    int txn0;
    txn0       = n_txn;
    stalls     = 0;
    cpu_req_i  = 1'b1;
    cpu_we_i   = we;
    cpu_addr_i = addr;
    cpu_data_i = wdata;
    #1;
    while (cpu_stall_o && stalls < 100) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    chk({tag, "_stalls"}, 128'(stalls), 128'(exp_stalls));
    if (!we) chk({tag, "_rdata"}, 128'(cpu_data_o), 128'(exp_rdata));
    @(negedge clk);
    cpu_req_i = 1'b0;
    cpu_we_i  = 1'b0;
    chk({tag, "_txns"}, 128'(n_txn - txn0), 128'(exp_txns));
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      mem_model[i] = {32'(i*16 + 12), 32'(i*16 + 8), 32'(i*16 + 4), 32'(i*16)};
    mem_model[4] = {32'h4, 32'h3, 32'h2, 32'h1};

    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("rst_stall", 128'(cpu_stall_o), 128'(0));
    chk("rst_mreq",  128'(mem_req_o),   128'(0));
    chk("rst_mwe",   128'(mem_we_o),    128'(0));
    chk("rst_rdata", 128'(cpu_data_o),  128'(0));
    chk("rst_maddr", 128'(mem_addr_o),  128'(0));
    chk("rst_mdata", mem_data_o,        128'(0));
    @(negedge clk);

    // Cold read: 1 miss cycle + 4 ALLOCATE cycles (ack on the 4th).
    acc("cold", 1'b0, 32'h40, '0, 5, 32'h1, 1);
    chk("cold_we",   128'(txn_we[0]),   128'(0));
    chk("cold_addr", 128'(txn_addr[0]), 128'(32'h40));
    acc("hit48", 1'b0, 32'h48, '0, 0, 32'h3, 0);

    // Write hit then read.
    acc("st44", 1'b1, 32'h44, 32'hDEADBEEF, 0, '0, 0);
    acc("ld44", 1'b0, 32'h44, '0, 0, 32'hDEADBEEF, 0);

    // Dirty eviction: WRITEBACK of 0x40 then ALLOCATE of 0x140.
    acc("evict", 1'b0, 32'h140, '0, 9, 32'h140, 2);
    chk("wb_we",    128'(txn_we[1]),   128'(1));
    chk("wb_addr",  128'(txn_addr[1]), 128'(32'h40));
    chk("wb_data",  txn_data[1], {32'h4, 32'h3, 32'hDEADBEEF, 32'h1});
    chk("al_we",    128'(txn_we[2]),   128'(0));
    chk("al_addr",  128'(txn_addr[2]), 128'(32'h140));
    // Victim 0x140 is clean, so this refetches the written-back line.
    acc("refetch", 1'b0, 32'h44, '0, 5, 32'hDEADBEEF, 1);

    // Store miss allocates, then merges the word.
    acc("stmiss", 1'b1, 32'h208, 32'h12345678, 5, '0, 1);
    acc("ld208", 1'b0, 32'h208, '0, 0, 32'h12345678, 0);
    acc("ld200", 1'b0, 32'h200, '0, 0, 32'h200, 0);

    // Idle cycles with a stray ack.
    for (int c = 0; c < 10; c++) begin
      stray_ack = (c == 4);
      @(negedge clk);
    end
    stray_ack = 1'b0;
    #1;
    chk("idle_stall", 128'(cpu_stall_o), 128'(0));
    chk("idle_mreq",  128'(mem_req_o),   128'(0));
    chk("idle_rdata", 128'(cpu_data_o),  128'(0));
    @(negedge clk);
    acc("idle_hit", 1'b0, 32'h44, '0, 0, 32'hDEADBEEF, 0);

    // Reset while ALLOCATE waits for an ack.
    ack_hold   = 1'b1;
    cpu_req_i  = 1'b1;
    cpu_addr_i = 32'h3A0;
    repeat (3) @(negedge clk);
    #1;
    chk("alloc_mreq",  128'(mem_req_o),   128'(1));
    chk("alloc_mwe",   128'(mem_we_o),    128'(0));
    chk("alloc_maddr", 128'(mem_addr_o),  128'(32'h3A0));
    chk("alloc_stall", 128'(cpu_stall_o), 128'(1));
    rst_i     = 1'b1;
    cpu_req_i = 1'b0;
    @(negedge clk);
    #1;
    chk("mrst_mreq",  128'(mem_req_o),   128'(0));
    chk("mrst_stall", 128'(cpu_stall_o), 128'(0));
    rst_i     = 1'b0;
    ack_hold  = 1'b0;
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    #1;
    chk("late_ack_mreq", 128'(mem_req_o), 128'(0));
    @(negedge clk);

    // Miss, hit, hit to 0x40 after reset.
    acc("st_miss", 1'b0, 32'h40, '0, 5, 32'h1, 1);
    acc("st_hit1", 1'b0, 32'h40, '0, 0, 32'h1, 0);
    acc("st_hit2", 1'b0, 32'h40, '0, 0, 32'h1, 0);
`ifdef DCACHE_STATS_EN
    chk("miss_cnt", 128'(miss_cnt_o), 128'(1));
    chk("hit_cnt",  128'(hit_cnt_o),  128'(2));
`endif
    acc("reaccess", 1'b0, 32'h3A0, '0, 5, 32'h3A0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
